uart_transmit: RTL and testbench

UART_TRANSMIT -- requirements
Module: uart_transmit

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_transmit_if.sv | 11 +
 rtl/uart_tx_hold.sv | 26 ++
 rtl/uart_transmit.sv | 129 ++++++++++++
 tb/tb_uart_transmit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART types, frame defaults and parity helper shared by transmitter and receiver
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   // even_mode=1 returns the XOR of the data bits; even_mode=0 returns its inverse
   function automatic logic uart_parity(input logic [7:0] data, input logic even_mode);
      return even_mode ? ^data : ~^data;
   endfunction

endpackage

// File: rtl/uart_transmit_if.sv
// rtl/uart_transmit_if.sv - byte handshake between the controller and the UART transmitter
interface uart_transmit_if;

   logic       tx_valid;
   logic [7:0] data_in;
   logic       tx_ready;

   modport master (output tx_valid, output data_in, input tx_ready);
   modport slave  (input tx_valid, input data_in, output tx_ready);

endinterface

// File: rtl/uart_tx_hold.sv
// rtl/uart_tx_hold.sv - one-entry holding register in front of the transmit shift register
module uart_tx_hold (
   input  logic           clk_in,
   input  logic           nreset,
   uart_transmit_if.slave host,
   input  logic           unload,
   output logic           full,
   output logic [7:0]     data
);

   assign host.tx_ready = ~full;

   // unload only ever happens while full, so it can never collide with an acceptance
   always_ff @(posedge clk_in or negedge nreset) begin
      if (!nreset) begin
         full <= 1'b0;
         data <= '0;
      end else if (unload) begin
         full <= 1'b0;
      end else if (host.tx_valid && !full) begin
         full <= 1'b1;
         data <= host.data_in;
      end
   end

endmodule

// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - UART transmitter: frame FSM, shift register and registered line outputs.
// Define UART_TX_PARITY_EN to add the parity bit between the data and stop bits.
module uart_transmit
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int STOP_BITS = UART_STOP_BITS
) (
   input  logic           clk_in,
   input  logic           nreset,
   input  logic           parity_mode,
   uart_transmit_if.slave host,
   output logic           serial_out,
   output logic           busy,
   output logic           tx_done
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_e state;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        stop_cnt;
   logic        hold_full;
   logic [7:0]  hold_data;
   logic        last_stop;
   logic        unload;

`ifdef UART_TX_PARITY_EN
   logic        par_bit;
`else
   logic        unused_parity_mode;
   assign unused_parity_mode = parity_mode;
`endif

   // a held byte is taken from IDLE or straight off the final stop bit, giving zero idle gap
   assign last_stop = (state == STOP) && (stop_cnt == STOP_LAST);
   assign unload    = hold_full && ((state == IDLE) || last_stop);

   uart_tx_hold u_hold (
      .clk_in (clk_in),
      .nreset (nreset),
      .host   (host),
      .unload (unload),
      .full   (hold_full),
      .data   (hold_data)
   );

   always_ff @(posedge clk_in or negedge nreset) begin
      if (!nreset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         serial_out <= 1'b1;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         if (unload) begin
            state      <= START;
            shreg      <= hold_data;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            serial_out <= 1'b0;
            busy       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit    <= uart_parity(hold_data, parity_mode);
`endif
         end else begin
            case (state)
               IDLE: begin
                  serial_out <= 1'b1;
                  busy       <= 1'b0;
               end
               START: begin
                  state      <= DATA;
                  serial_out <= shreg[0];
               end
               DATA: begin
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     state      <= PARITY;
                     serial_out <= par_bit;
`else
                     state      <= STOP;
                     serial_out <= 1'b1;
                     tx_done    <= (STOP_LAST == 1'b0);
`endif
                  end else begin
                     bit_cnt    <= bit_cnt + 3'd1;
                     shreg      <= {1'b0, shreg[7:1]};
                     serial_out <= shreg[1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  state      <= STOP;
                  serial_out <= 1'b1;
                  tx_done    <= (STOP_LAST == 1'b0);
               end
`endif
               STOP: begin
                  serial_out <= 1'b1;
                  if (stop_cnt == STOP_LAST) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     stop_cnt <= 1'b0;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                     tx_done  <= ((stop_cnt + 1'b1) == STOP_LAST);
                  end
               end
               default: begin
                  state      <= IDLE;
                  serial_out <= 1'b1;
                  busy       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - self-checking bench for uart_transmit against a frame-queue reference model
module tb_uart_transmit;

   localparam int STOP_BITS = 2;
`ifdef UART_TX_PARITY_EN
   localparam int FLEN = 1 + 8 + 1 + STOP_BITS;
`else
   localparam int FLEN = 1 + 8 + STOP_BITS;
`endif

   logic clk_in = 1'b0;
   logic nreset;
   logic parity_mode;
   logic serial_out;
   logic busy;
   logic tx_done;

   uart_transmit_if bus();

   uart_transmit #(.DATA_BITS(8), .STOP_BITS(STOP_BITS)) dut (
      .clk_in      (clk_in),
      .nreset      (nreset),
      .parity_mode (parity_mode),
      .host        (bus),
      .serial_out  (serial_out),
      .busy        (busy),
      .tx_done     (tx_done)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // model: queue of line bits still to come; entry = bit | last_of_frame<<1 | in_frame<<2
   int         exp_q[$];
   bit         m_full;
   logic [7:0] m_byte;
   logic       exp_ser, exp_busy, exp_done;
   int         got_bits[$];
   int         done_bits[$];

`ifdef UART_TX_PARITY_EN
   int a5_ref[$] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1};
`else
   int a5_ref[$] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [7:0] b, input logic pm);
      exp_q.push_back(4);
      for (int i = 0; i < 8; i++) exp_q.push_back(4 + int'(b[i]));
`ifdef UART_TX_PARITY_EN
      begin
         int ones;
         ones = 0;
         for (int i = 0; i < 8; i++) ones += int'(b[i]);
         exp_q.push_back(4 + (pm ? (ones % 2) : (1 - ones % 2)));
      end
`else
      if (pm === 1'bx) exp_q.push_back(0);
`endif
      for (int s = 0; s < STOP_BITS; s++) exp_q.push_back(5 + ((s == STOP_BITS - 1) ? 2 : 0));
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_full   = 1'b0;
      exp_ser  = 1'b1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
   endtask

   task automatic model_edge();
      bit fb;
      int e;
      fb = m_full;
      if (exp_q.size() == 0 && fb) begin
         push_frame(m_byte, parity_mode);
         m_full = 1'b0;
      end
      if (bus.tx_valid && !fb) begin
         m_full = 1'b1;
         m_byte = bus.data_in;
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         exp_ser  = e[0];
         exp_done = e[1];
         exp_busy = e[2];
      end else begin
         exp_ser  = 1'b1;
         exp_done = 1'b0;
         exp_busy = 1'b0;
      end
   endtask

   task automatic cycle();
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
      check("serial_out", serial_out, exp_ser);
      check("busy", busy, exp_busy);
      check("tx_done", tx_done, exp_done);
      check("tx_ready", bus.tx_ready, !m_full);
      got_bits.push_back(int'(serial_out));
      done_bits.push_back(int'(tx_done));
   endtask

   task automatic pulse_reset();
      #2 nreset = 1'b0;
      #1;
      check("rst_serial_out", serial_out, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_tx_done", tx_done, 1'b0);
      check("rst_tx_ready", bus.tx_ready, 1'b1);
      model_reset();
      @(negedge clk_in);
      nreset = 1'b1;
   endtask

   task automatic send_one(input logic [7:0] b, input logic pm);
      parity_mode  = pm;
      bus.tx_valid = 1'b1;
      bus.data_in  = b;
      cycle();
      bus.tx_valid = 1'b0;
      got_bits.delete();
      done_bits.delete();
      for (int i = 0; i < FLEN; i++) cycle();
      cycle();
   endtask

   initial begin
      int busy_cnt;
      int first_idle;

      bus.tx_valid = 1'b0;
      bus.data_in  = 8'h00;
      parity_mode  = 1'b0;
      nreset       = 1'b1;
      #1 nreset    = 1'b0;
      #2;
      check("init_serial_out", serial_out, 1'b1);
      check("init_busy", busy, 1'b0);
      check("init_tx_done", tx_done, 1'b0);
      check("init_tx_ready", bus.tx_ready, 1'b1);
      model_reset();
      @(negedge clk_in);
      nreset = 1'b1;
      repeat (2) cycle();

      // known frame for 0xA5
      send_one(8'hA5, 1'b1);
      for (int i = 0; i < FLEN; i++) begin
         check("a5_bit", got_bits[i], a5_ref[i]);
         check("a5_done", done_bits[i], (i == FLEN - 1));
      end

`ifdef UART_TX_PARITY_EN
      send_one(8'h01, 1'b0);
      check("parity_odd_01", got_bits[9], 0);
      send_one(8'h01, 1'b1);
      check("parity_even_01", got_bits[9], 1);
`endif

      // back-to-back frames, second byte offered while the first is in DATA
      parity_mode  = 1'($urandom);
      bus.tx_valid = 1'b1;
      bus.data_in  = 8'h55;
      cycle();
      busy_cnt   = 0;
      first_idle = -1;
      for (int i = 0; i < 2 * FLEN + 6; i++) begin
         bus.tx_valid = (i == 3);
         bus.data_in  = 8'hAA;
         cycle();
         if (i == 4) check("b2b_ready_low", bus.tx_ready, 1'b0);
         busy_cnt += int'(busy);
         if (!busy && first_idle < 0) first_idle = i;
      end
      check("b2b_busy_cycles", busy_cnt, 2 * FLEN);
      check("b2b_first_idle", first_idle, 2 * FLEN);

      // holder full with tx_valid held and data_in changing every cycle
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 3 * FLEN; i++) begin
         bus.data_in = 8'($urandom);
         cycle();
      end
      bus.tx_valid = 1'b0;
      repeat (2 * FLEN + 2) cycle();

      // reset during data bit 3 with a second byte pending in the holder
      bus.tx_valid = 1'b1;
      bus.data_in  = 8'h5A;
      cycle();
      bus.data_in  = 8'hC3;
      cycle();
      cycle();
      bus.tx_valid = 1'b0;
      repeat (3) cycle();
      check("pre_rst_busy", busy, 1'b1);
      pulse_reset();
      busy_cnt = 0;
      for (int i = 0; i < 2 * FLEN; i++) begin
         cycle();
         busy_cnt += int'(busy);
      end
      check("post_rst_no_frame", busy_cnt, 0);

      // randomized traffic, parity mode flipping mid-frame, occasional resets
      for (int i = 0; i < 3000; i++) begin
         bus.tx_valid = ($urandom_range(0, 2) == 0);
         bus.data_in  = 8'($urandom);
         if ($urandom_range(0, 7) == 0) parity_mode = ~parity_mode;
         if ($urandom_range(0, 499) == 0) pulse_reset();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
